mem_cmd_sequencer: RTL and testbench

- Upstream request front-end for the single-port `Memory` block.
- Accepts write and read commands on a valid/ready stream and drives the `Memory` control pins (`en`, `address`, `data_in`).
- Captures returned read data (`data_out` qualified by `valid_out`) into a response buffer that is drained by a valid/ready response stream.
- Read issue is credit-limited, so a response is never dropped.

---
 rtl/mem_seq_pkg.sv | 26 ++
 rtl/mem_rsp_fifo.sv | 80 ++++++++
 rtl/mem_cmd_sequencer.sv | 154 +++++++++++++++
 tb/tb_mem_cmd_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_seq_pkg.sv
// ----------------------------------------------------------------------------
// mem_seq_pkg : shared types and constants for the memory command sequencer
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mem_seq_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int DATA_W_DEF = 32;

  // Cycles from the edge that samples a read address to valid_out.
  localparam int RD_LAT = 1;

  typedef logic [ADDR_W_DEF-1:0] addr_t;
  typedef logic [DATA_W_DEF-1:0] data_t;

  typedef struct packed {
    data_t data;
    addr_t addr;
    logic  err;
  } rsp_t;

endpackage

`default_nettype wire

// File: rtl/mem_rsp_fifo.sv
// ----------------------------------------------------------------------------
// mem_rsp_fifo : power-of-2 deep FIFO holding read responses, head shown on data_o
// Revision     : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_rsp_fifo
  import mem_seq_pkg::*;
#(
  parameter type T     = rsp_t,
  parameter int  DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_i,
  input  T                       data_i,
  input  logic                   pop_i,
  output T                       data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;

  T                   mem_q [DEPTH];
  logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_cnt_w-1:0] count_q, count_d;
  logic               w_do_push;
  logic               w_do_pop;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == c_cnt_w'(DEPTH));
  assign count_o   = count_q;
  assign data_o    = mem_q[rd_ptr_q];
  assign w_do_pop  = pop_i && !empty_o;
  // When full, a push is only taken alongside a pop; the new entry lands in
  // the slot being vacated, which is read out before this edge.
  assign w_do_push = push_i && (!full_o || w_do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_do_push) wr_ptr_d = wr_ptr_q + c_ptr_w'(1);
    if (w_do_pop)  rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
    case ({w_do_push, w_do_pop})
      2'b10:   count_d = count_q + c_cnt_w'(1);
      2'b01:   count_d = count_q - c_cnt_w'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) mem_q[wr_ptr_q] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push_i && full_o && !w_do_pop));
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// mem_cmd_sequencer : credit-limited command front-end for a single-port Memory
// Revision          : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mem_cmd_sequencer
  import mem_seq_pkg::*;
#(
  parameter int ADDR_W    = $bits(addr_t),
  parameter int DATA_W    = $bits(data_t),
  parameter int RSP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_err,
  output logic              en,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] data_out,
  input  logic              valid_out,
  output logic              busy
);

  localparam int c_stages = RD_LAT + 1;
  localparam int c_cnt_w  = $clog2(RSP_DEPTH) + 1;
  localparam int c_inf_w  = $clog2(c_stages + 1);
  localparam int c_use_w  = ((c_cnt_w > c_inf_w) ? c_cnt_w : c_inf_w) + 1;

  typedef struct packed {
    logic              tag;
    logic [ADDR_W-1:0] addr;
  } trk_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic              err;
  } rsp_entry_t;

  trk_t [c_stages-1:0] trk_q, trk_d;
  logic                en_q, en_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;

  logic                w_cmd_fire;
  logic [c_inf_w-1:0]  w_inflight;
  logic [c_use_w-1:0]  w_used;
  rsp_entry_t          w_push_entry;
  rsp_entry_t          w_head;
  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [c_cnt_w-1:0]  w_count;

  assign w_cmd_fire = cmd_valid && cmd_ready;

  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < c_stages; i++) begin
      w_inflight = w_inflight + c_inf_w'(trk_q[i].tag);
    end
  end

  // Buffered plus in-flight reads reserve buffer slots, so every tagged
  // return is guaranteed a place to land.
  assign w_used    = c_use_w'(w_count) + c_use_w'(w_inflight);
  assign cmd_ready = !rst && (w_used < c_use_w'(RSP_DEPTH));

  always_comb begin
    en_d    = w_cmd_fire && cmd_wr;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    if (w_cmd_fire) begin
      addr_d = cmd_addr;
      if (cmd_wr) wdata_d = cmd_wdata;
    end
    trk_d          = trk_q;
    trk_d[0].tag   = w_cmd_fire && !cmd_wr;
    trk_d[0].addr  = cmd_addr;
    for (int i = 1; i < c_stages; i++) begin
      trk_d[i] = trk_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      trk_q   <= '0;
    end else begin
      en_q    <= en_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      trk_q   <= trk_d;
    end
  end

  // The oldest stage lines up with valid_out; a tag without valid_out
  // becomes an error response instead of being lost.
  always_comb begin
    w_push            = trk_q[c_stages-1].tag;
    w_push_entry.data = valid_out ? data_out : '0;
    w_push_entry.addr = trk_q[c_stages-1].addr;
    w_push_entry.err  = !valid_out;
  end

  assign w_pop = rsp_ready && !w_empty;

  mem_rsp_fifo #(
    .T     (rsp_entry_t),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .data_i  (w_push_entry),
    .pop_i   (w_pop),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (w_count)
  );

  assign rsp_valid = !w_empty;
  assign rsp_data  = rsp_valid ? w_head.data : '0;
  assign rsp_addr  = rsp_valid ? w_head.addr : '0;
  assign rsp_err   = rsp_valid && w_head.err;

  assign en      = en_q;
  assign address = addr_q;
  assign data_in = wdata_q;
  assign busy    = (w_inflight != '0) || !w_empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(w_push && w_full && !w_pop));
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_cmd_sequencer.sv
// ----------------------------------------------------------------------------
// tb_mem_cmd_sequencer : directed bench with a behavioural single-port Memory
// Revision             : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_mem_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_wr = 1'b0;
  logic [3:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic [3:0]  rsp_addr;
  logic        rsp_err;
  logic        en;
  logic [3:0]  address;
  logic [31:0] data_in;
  logic [31:0] data_out = '0;
  logic        valid_out = 1'b0;
  logic        busy;

  int checks = 0;
  int failures = 0;

  mem_cmd_sequencer #(
    .ADDR_W    (4),
    .DATA_W    (32),
    .RSP_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_wr    (cmd_wr),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_addr  (rsp_addr),
    .rsp_err   (rsp_err),
    .en        (en),
    .address   (address),
    .data_in   (data_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Memory model: one-cycle registered read; one armed read of addr 7 fails.
  logic [31:0] mem_arr [16];
  logic        miss_armed = 1'b0;
  logic        miss_done  = 1'b0;
  always @(posedge clk) begin
    if (en) mem_arr[address] <= data_in;
    if (!en && miss_armed && !miss_done && address == 4'd7) begin
      valid_out <= 1'b0;
      data_out  <= 32'hBAD0BAD0;
      miss_done <= 1'b1;
    end else begin
      valid_out <= !en;
      data_out  <= mem_arr[address];
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Waits (bounded) for a response, checks it, and lets it pop at the next edge.
  task automatic expect_rsp(input string nm, input logic [3:0] a, input logic [31:0] d,
                            input logic e);
    int n = 0;
    while (!rsp_valid && n < 10) begin
      tick();
      n++;
    end
    chk({nm, " valid"}, 64'(rsp_valid), 64'd1);
    chk({nm, " addr"},  64'(rsp_addr),  64'(a));
    chk({nm, " data"},  64'(rsp_data),  64'(d));
    chk({nm, " err"},   64'(rsp_err),   64'(e));
    tick();
  endtask

  function automatic logic [31:0] pat(input logic [3:0] a);
    return 32'hC0DE0000 | {28'd0, a};
  endfunction

  typedef struct {
    logic        wr;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t       vecs [12];
  logic [3:0] cmd_q [$];
  logic [3:0] exp_q [$];

  initial begin
    int idx;
    int seen;
    int seen_busy;

    for (int i = 0; i < 8; i++) begin
      vecs[i] = '{wr: 1'b1, addr: 4'(i), wdata: 32'hC0DE0000 + 32'(i), exp: 32'h0};
    end
    vecs[8]  = '{wr: 1'b0, addr: 4'd5, wdata: 32'h0, exp: 32'hC0DE0005};
    vecs[9]  = '{wr: 1'b0, addr: 4'd0, wdata: 32'h0, exp: 32'hC0DE0000};
    vecs[10] = '{wr: 1'b0, addr: 4'd7, wdata: 32'h0, exp: 32'hC0DE0007};
    vecs[11] = '{wr: 1'b0, addr: 4'd3, wdata: 32'h0, exp: 32'hC0DE0003};

    // Reset state
    tick();
    tick();
    chk("rst cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst en",        64'(en),        64'd0);
    chk("rst address",   64'(address),   64'd0);
    chk("rst data_in",   64'(data_in),   64'd0);
    chk("rst rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst rsp_data",  64'(rsp_data),  64'd0);
    chk("rst busy",      64'(busy),      64'd0);
    rst = 1'b0;
    #1;
    chk("post-rst cmd_ready", 64'(cmd_ready), 64'd1);

    // Write then read back with exact latency
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 4'd3; cmd_wdata = 32'hDEADBEEF;
    tick();
    chk("t1 wr en",      64'(en),      64'd1);
    chk("t1 wr address", 64'(address), 64'd3);
    chk("t1 wr data_in", 64'(data_in), 64'hDEADBEEF);
    cmd_wr = 1'b0;
    tick();
    cmd_valid = 1'b0;
    chk("t1 rd en",        64'(en),        64'd0);
    chk("t1 rd address",   64'(address),   64'd3);
    chk("t1 N+1 rsp_valid", 64'(rsp_valid), 64'd0);
    chk("t1 N+1 busy",     64'(busy),      64'd1);
    tick();
    chk("t1 N+2 rsp_valid", 64'(rsp_valid), 64'd0);
    tick();
    chk("t1 N+3 rsp_valid", 64'(rsp_valid), 64'd1);
    chk("t1 rsp_data",      64'(rsp_data),  64'hDEADBEEF);
    chk("t1 rsp_addr",      64'(rsp_addr),  64'd3);
    chk("t1 rsp_err",       64'(rsp_err),   64'd0);
    tick();
    chk("t1 drained rsp_valid", 64'(rsp_valid), 64'd0);
    chk("t1 drained busy",      64'(busy),      64'd0);

    // Table: preload memory, then read selected addresses
    for (int i = 0; i < 12; i++) begin
      cmd_valid = 1'b1; cmd_wr = vecs[i].wr; cmd_addr = vecs[i].addr;
      cmd_wdata = vecs[i].wdata;
      chk($sformatf("vec%0d cmd_ready", i), 64'(cmd_ready), 64'd1);
      tick();
      cmd_valid = 1'b0;
      if (vecs[i].wr) begin
        chk($sformatf("vec%0d en", i),      64'(en),      64'd1);
        chk($sformatf("vec%0d data_in", i), 64'(data_in), 64'(vecs[i].wdata));
      end else begin
        chk($sformatf("vec%0d en", i), 64'(en), 64'd0);
      end
      chk($sformatf("vec%0d address", i), 64'(address), 64'(vecs[i].addr));
      if (!vecs[i].wr) expect_rsp($sformatf("vec%0d rsp", i), vecs[i].addr, vecs[i].exp, 1'b0);
    end

    // Credit limit with stalled consumer: only 4 of 6 reads accepted
    rsp_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      cmd_valid = (idx < 6); cmd_wr = 1'b0; cmd_addr = 4'(idx);
      if (cmd_valid && cmd_ready) idx++;
      tick();
    end
    cmd_valid = 1'b0;
    chk("t2 accepted",   64'(idx),       64'd4);
    chk("t2 cmd_ready",  64'(cmd_ready), 64'd0);
    chk("t2 rsp_valid",  64'(rsp_valid), 64'd1);
    chk("t2 head addr",  64'(rsp_addr),  64'd0);
    tick();
    chk("t2 head held",  64'(rsp_addr),  64'd0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) expect_rsp($sformatf("t2 rsp%0d", i), 4'(i), pat(4'(i)), 1'b0);
    chk("t2 cmd_ready back", 64'(cmd_ready), 64'd1);
    chk("t2 busy idle",      64'(busy),      64'd0);

    // Fill the buffer, then stream reads while draining every cycle
    rsp_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      cmd_valid = (idx < 4); cmd_wr = 1'b0; cmd_addr = 4'(idx);
      if (cmd_valid && cmd_ready) idx++;
      tick();
    end
    cmd_valid = 1'b0;
    chk("t3 fill cmd_ready", 64'(cmd_ready), 64'd0);
    exp_q = '{4'd0, 4'd1, 4'd2, 4'd3};
    cmd_q = '{4'd4, 4'd5, 4'd6, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0, 4'd1, 4'd2, 4'd3};
    rsp_ready = 1'b1;
    for (int c = 0; c < 80; c++) begin
      cmd_valid = (cmd_q.size() > 0);
      cmd_addr  = cmd_valid ? cmd_q[0] : 4'd0;
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("t3 unexpected rsp", 64'(rsp_valid), 64'd0);
        end else begin
          chk("t3 stream addr", 64'(rsp_addr), 64'(exp_q[0]));
          chk("t3 stream data", 64'(rsp_data), 64'(pat(exp_q[0])));
          chk("t3 stream err",  64'(rsp_err),  64'd0);
          void'(exp_q.pop_front());
        end
      end
      if (cmd_valid && cmd_ready) exp_q.push_back(cmd_q.pop_front());
      tick();
      if (cmd_q.size() == 0 && exp_q.size() == 0) break;
    end
    cmd_valid = 1'b0;
    chk("t3 all delivered", 64'(cmd_q.size() + exp_q.size()), 64'd0);
    chk("t3 busy idle",     64'(busy), 64'd0);

    // Missing valid_out on a tagged read, then a normal read
    miss_armed = 1'b1;
    cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 4'd7;
    chk("t4 ready rd7", 64'(cmd_ready), 64'd1);
    tick();
    cmd_addr = 4'd6;
    chk("t4 ready rd6", 64'(cmd_ready), 64'd1);
    tick();
    cmd_valid = 1'b0;
    expect_rsp("t4 miss", 4'd7, 32'h0, 1'b1);
    expect_rsp("t4 next", 4'd6, 32'hC0DE0006, 1'b0);

    // Reset with 2 reads in flight and 2 buffered
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 4'(i);
      chk($sformatf("t5 ready%0d", i), 64'(cmd_ready), 64'd1);
      tick();
    end
    cmd_valid = 1'b0;
    chk("t5 busy before", 64'(busy),      64'd1);
    chk("t5 buffered",    64'(rsp_valid), 64'd1);
    rst = 1'b1;
    tick();
    chk("t5 rsp_valid", 64'(rsp_valid), 64'd0);
    chk("t5 busy",      64'(busy),      64'd0);
    chk("t5 en",        64'(en),        64'd0);
    chk("t5 address",   64'(address),   64'd0);
    chk("t5 rsp_data",  64'(rsp_data),  64'd0);
    chk("t5 rsp_addr",  64'(rsp_addr),  64'd0);
    chk("t5 cmd_ready", 64'(cmd_ready), 64'd0);
    rst = 1'b0;
    rsp_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (rsp_valid) seen++;
    end
    chk("t5 stale responses", 64'(seen), 64'd0);

    // Idle with the memory answering every cycle
    seen = 0;
    seen_busy = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (rsp_valid) seen++;
      if (busy) seen_busy++;
    end
    chk("t6 idle rsp_valid", 64'(seen),      64'd0);
    chk("t6 idle busy",      64'(seen_busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
